// File: rtl/mining_pkg.sv
// Shared types for the mining job sequencer.
//   state_t  : sequencer FSM states
//   header_t : block-header fields handed to the supervisor
//   result_t : per-job result record (job tag carried separately)
//   make_result : builds a result record
package mining_pkg;

    // Number of initial RUN cycles in which sup_complete is ignored. A complete
    // flag left high by the previous run must not end the new run.
    localparam int STALE_GUARD = 2;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        DECIDE,
        REPORT
    } state_t;

    typedef struct packed {
        logic [31:0]  version;
        logic [255:0] prev_hash;
        logic [255:0] merkle;
        logic [31:0]  timestamp;
        logic [31:0]  bits;
        logic [31:0]  target;
    } header_t;

    localparam int HDR_W = $bits(header_t);

    typedef struct packed {
        logic         success;
        logic         aborted;
        logic [31:0]  nonce;
        logic [255:0] hash;
        logic [31:0]  timestamp;
        logic [7:0]   rolls;
    } result_t;

    function automatic result_t make_result(input logic success, input logic aborted,
                                            input logic [31:0] nonce, input logic [255:0] hash,
                                            input logic [31:0] timestamp, input logic [7:0] rolls);
        result_t r;
        r.success   = success;
        r.aborted   = aborted;
        r.nonce     = nonce;
        r.hash      = hash;
        r.timestamp = timestamp;
        r.rolls     = rolls;
        return r;
    endfunction

endpackage

// File: rtl/job_fifo.sv
// Synchronous FIFO holding queued jobs ({job_id, header}).
//   clk, reset         : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data    : write when push && !full
//   pop, pop_data      : read when pop && !empty; pop_data shows the head entry
//   full, empty        : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module job_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push, do_pop;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: nothing is read until it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mining_job_sequencer.sv
// Feeds block-header jobs to the multi-miner supervisor one at a time.
//   clk, reset          : clock, synchronous active-high reset
//   job_*               : valid/ready job queue input (tag + header fields)
//   abort               : one-cycle pulse, cancels the job in flight
//   sup_reset/sup_start : supervisor control
//   sup_<header>        : registered header fields to the supervisor
//   sup_complete/success/nonce/hash : supervisor status
//   res_*               : valid/ready result record, one per job
// Each launch holds sup_reset for RESET_CYCLES, then runs with sup_start. A run
// that exhausts the nonce space without success bumps the timestamp and relaunches,
// up to MAX_ROLLS times.
module mining_job_sequencer
    import mining_pkg::*;
#(
    parameter int JOB_DEPTH    = 2,
    parameter int MAX_ROLLS    = 4,
    parameter int RESET_CYCLES = 2,
    parameter int ID_W         = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            job_valid,
    output logic            job_ready,
    input  logic [ID_W-1:0] job_id,
    input  logic [31:0]     job_version,
    input  logic [255:0]    job_prev_hash,
    input  logic [255:0]    job_merkle,
    input  logic [31:0]     job_timestamp,
    input  logic [31:0]     job_bits,
    input  logic [31:0]     job_target,
    input  logic            abort,
    output logic            sup_reset,
    output logic            sup_start,
    output logic [31:0]     sup_version,
    output logic [255:0]    sup_prev_hash,
    output logic [255:0]    sup_merkle,
    output logic [31:0]     sup_timestamp,
    output logic [31:0]     sup_bits,
    output logic [31:0]     sup_target,
    input  logic            sup_complete,
    input  logic            sup_success,
    input  logic [31:0]     sup_nonce,
    input  logic [255:0]    sup_hash,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [ID_W-1:0] res_id,
    output logic            res_success,
    output logic            res_aborted,
    output logic [31:0]     res_nonce,
    output logic [255:0]    res_hash,
    output logic [31:0]     res_timestamp,
    output logic [7:0]      res_rolls
);

    localparam int             FIFO_W        = ID_W + HDR_W;
    localparam logic [7:0]     MAX_ROLLS_C   = MAX_ROLLS[7:0];
    localparam logic [7:0]     LAUNCH_LAST   = 8'(RESET_CYCLES - 1);
    localparam logic [1:0]     STALE_GUARD_C = STALE_GUARD[1:0];

    header_t         in_hdr, fifo_hdr, job_hdr, job_hdr_nxt, launch_hdr, sup_hdr;
    logic [ID_W-1:0] fifo_id, job_id_q, job_id_nxt, res_id_q;
    logic [FIFO_W-1:0] fifo_rd;
    logic            fifo_full, fifo_empty, pop;
    state_t          state, state_nxt;
    logic [7:0]      launch_cnt, launch_cnt_nxt, rolls, rolls_nxt;
    logic [1:0]      guard_cnt, guard_cnt_nxt;
    result_t         res_q, res_nxt;

    // Held low during reset so nothing is accepted before the queue is known empty.
    assign job_ready = !reset && !fifo_full;
    assign in_hdr    = {job_version, job_prev_hash, job_merkle, job_timestamp, job_bits, job_target};
    assign {fifo_id, fifo_hdr} = fifo_rd;

    job_fifo #(.WIDTH(FIFO_W), .DEPTH(JOB_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (job_valid && job_ready),
        .push_data ({job_id, in_hdr}),
        .pop       (pop),
        .pop_data  (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_nxt      = state;
        launch_cnt_nxt = launch_cnt;
        guard_cnt_nxt  = guard_cnt;
        rolls_nxt      = rolls;
        job_hdr_nxt    = job_hdr;
        job_id_nxt     = job_id_q;
        res_nxt        = res_q;
        pop            = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop            = 1'b1;
                    job_hdr_nxt    = fifo_hdr;
                    job_id_nxt     = fifo_id;
                    rolls_nxt      = '0;
                    launch_cnt_nxt = '0;
                    state_nxt      = LAUNCH;
                end
            end
            LAUNCH: begin
                if (abort) begin
                    res_nxt   = make_result(1'b0, 1'b1, '0, '0, sup_timestamp, rolls);
                    state_nxt = REPORT;
                end else if (launch_cnt == LAUNCH_LAST) begin
                    guard_cnt_nxt = '0;
                    state_nxt     = RUN;
                end else begin
                    launch_cnt_nxt = launch_cnt + 8'd1;
                end
            end
            RUN: begin
                if (abort) begin
                    res_nxt   = make_result(1'b0, 1'b1, '0, '0, sup_timestamp, rolls);
                    state_nxt = REPORT;
                end else if (guard_cnt != STALE_GUARD_C) begin
                    guard_cnt_nxt = guard_cnt + 2'd1;
                end else if (sup_complete) begin
                    state_nxt = DECIDE;
                end
            end
            DECIDE: begin
                if (abort) begin
                    res_nxt   = make_result(1'b0, 1'b1, '0, '0, sup_timestamp, rolls);
                    state_nxt = REPORT;
                end else if (sup_success) begin
                    res_nxt   = make_result(1'b1, 1'b0, sup_nonce, sup_hash, sup_timestamp, rolls);
                    state_nxt = REPORT;
                end else if (rolls < MAX_ROLLS_C) begin
                    rolls_nxt      = rolls + 8'd1;
                    launch_cnt_nxt = '0;
                    state_nxt      = LAUNCH;
                end else begin
                    res_nxt   = make_result(1'b0, 1'b0, '0, '0, sup_timestamp, rolls);
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Header for the next launch: timestamp advanced by the roll count (wraps at 32 bits).
    always_comb begin
        launch_hdr           = job_hdr_nxt;
        launch_hdr.timestamp = job_hdr_nxt.timestamp + {24'b0, rolls_nxt};
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            launch_cnt <= '0;
            guard_cnt  <= '0;
            rolls      <= '0;
            job_hdr    <= '0;
            job_id_q   <= '0;
            res_q      <= '0;
            res_id_q   <= '0;
            res_valid  <= 1'b0;
            sup_reset  <= 1'b1;
            sup_start  <= 1'b0;
            sup_hdr    <= '0;
        end else begin
            state      <= state_nxt;
            launch_cnt <= launch_cnt_nxt;
            guard_cnt  <= guard_cnt_nxt;
            rolls      <= rolls_nxt;
            job_hdr    <= job_hdr_nxt;
            job_id_q   <= job_id_nxt;
            res_q      <= res_nxt;
            res_valid  <= (state_nxt == REPORT);
            // The supervisor keeps start through DECIDE so its success/nonce stay valid.
            sup_reset  <= (state_nxt inside {IDLE, LAUNCH, REPORT});
            sup_start  <= (state_nxt inside {RUN, DECIDE});
            if (state_nxt == REPORT && state != REPORT) res_id_q <= job_id_q;
            if (state_nxt == LAUNCH && state != LAUNCH) sup_hdr <= launch_hdr;
        end
    end

    assign sup_version   = sup_hdr.version;
    assign sup_prev_hash = sup_hdr.prev_hash;
    assign sup_merkle    = sup_hdr.merkle;
    assign sup_timestamp = sup_hdr.timestamp;
    assign sup_bits      = sup_hdr.bits;
    assign sup_target    = sup_hdr.target;

    assign res_id        = res_id_q;
    assign res_success   = res_q.success;
    assign res_aborted   = res_q.aborted;
    assign res_nonce     = res_q.nonce;
    assign res_hash      = res_q.hash;
    assign res_timestamp = res_q.timestamp;
    assign res_rolls     = res_q.rolls;

endmodule

// File: tb/tb_mining_job_sequencer.sv
module tb_mining_job_sequencer;
    localparam int ID_W = 8;
    localparam int RC   = 2;
    localparam int MAXR = 4;
    localparam logic [31:0]  K_NONCE = 32'h0000_1234;
    localparam logic [255:0] K_HASH  = {16'hABCD, 240'h0123_4567_89AB_CDEF};

    logic            clk = 1'b0;
    logic            reset;
    logic            job_valid, job_ready;
    logic [ID_W-1:0] job_id;
    logic [31:0]     job_version, job_timestamp, job_bits, job_target;
    logic [255:0]    job_prev_hash, job_merkle;
    logic            abort;
    logic            sup_reset, sup_start;
    logic [31:0]     sup_version, sup_timestamp, sup_bits, sup_target;
    logic [255:0]    sup_prev_hash, sup_merkle;
    logic            sup_complete, sup_success;
    logic [31:0]     sup_nonce;
    logic [255:0]    sup_hash;
    logic            res_valid, res_ready;
    logic [ID_W-1:0] res_id;
    logic            res_success, res_aborted;
    logic [31:0]     res_nonce, res_timestamp;
    logic [255:0]    res_hash;
    logic [7:0]      res_rolls;

    mining_job_sequencer #(.JOB_DEPTH(2), .MAX_ROLLS(MAXR), .RESET_CYCLES(RC), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
        .job_version(job_version), .job_prev_hash(job_prev_hash), .job_merkle(job_merkle),
        .job_timestamp(job_timestamp), .job_bits(job_bits), .job_target(job_target),
        .abort(abort),
        .sup_reset(sup_reset), .sup_start(sup_start),
        .sup_version(sup_version), .sup_prev_hash(sup_prev_hash), .sup_merkle(sup_merkle),
        .sup_timestamp(sup_timestamp), .sup_bits(sup_bits), .sup_target(sup_target),
        .sup_complete(sup_complete), .sup_success(sup_success),
        .sup_nonce(sup_nonce), .sup_hash(sup_hash),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_success(res_success), .res_aborted(res_aborted), .res_nonce(res_nonce),
        .res_hash(res_hash), .res_timestamp(res_timestamp), .res_rolls(res_rolls)
    );

    always #5 clk = ~clk;

    // Supervisor model: counts cycles under sup_start, raises complete at cycle k_done,
    // succeeds only once k_fail runs of the current job have failed.
    int k_done = 10, k_fail = 0, run_base = 0;
    bit k_stale = 1'b0;
    int m_cyc = 0, run_idx = 0, cyc = 0;
    bit m_started = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sup_reset) begin
            m_cyc <= 0;
            if (m_started) run_idx <= run_idx + 1;
            m_started <= 1'b0;
        end else if (sup_start) begin
            m_started <= 1'b1;
            if (m_cyc < 100000) m_cyc <= m_cyc + 1;
        end
    end

    assign sup_complete = (sup_start && m_cyc >= k_done) || (k_stale && m_cyc < 2);
    assign sup_success  = sup_start && (m_cyc >= k_done) && ((run_idx - run_base) >= k_fail);
    assign sup_nonce    = K_NONCE;
    assign sup_hash     = K_HASH;

    typedef struct {
        logic [7:0]   id;
        logic         success;
        logic         aborted;
        logic [31:0]  nonce;
        logic [255:0] hash;
        logic [31:0]  ts;
        logic [7:0]   rolls;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ts_log[$];
    int          streak_log[$];
    int          streak = 0, t_cmp = 0;
    bit          prev_start = 1'b0, prev_valid = 1'b0, lat_en = 1'b0;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Per-cycle observation at the falling edge: launch log, latency, scoreboard.
    task automatic mon();
        exp_t e;
        if (sup_start && !prev_start) begin
            ts_log.push_back(sup_timestamp);
            streak_log.push_back(streak);
        end
        streak = sup_reset ? streak + 1 : 0;
        if (sup_start && m_cyc == k_done) t_cmp = cyc;
        if (lat_en && res_valid && !prev_valid) chk("complete_to_valid", 256'(cyc - t_cmp), 2);
        if (res_valid && res_ready) begin
            if (sb.size() == 0) chk("unexpected_result", res_valid, 0);
            else begin
                e = sb.pop_front();
                chk("res_id", res_id, e.id);
                chk("res_success", res_success, e.success);
                chk("res_aborted", res_aborted, e.aborted);
                chk("res_nonce", res_nonce, e.nonce);
                chk("res_hash", res_hash, e.hash);
                chk("res_timestamp", res_timestamp, e.ts);
                chk("res_rolls", res_rolls, e.rolls);
            end
        end
        prev_start = sup_start;
        prev_valid = res_valid;
    endtask

    // One clock: observe at negedge, return 1 time unit after the next rising edge.
    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [7:0] id, input logic [31:0] ts,
                            input bit succ, input bit abrt, input int rolls);
        exp_t e;
        int n = 0;
        job_valid     = 1'b1;
        job_id        = id;
        job_timestamp = ts;
        job_version   = {24'h200000, id};
        job_prev_hash = {32{id}};
        job_merkle    = ~{32{id}};
        job_bits      = 32'h1703_0000 | {24'h0, id};
        job_target    = 32'd20;
        while (!job_ready && n < 200) begin tick(); n++; end
        if (!job_ready) chk("push_timeout", job_ready, 1);
        else begin
            e.id      = id;
            e.success = succ;
            e.aborted = abrt;
            e.nonce   = succ ? K_NONCE : 32'h0;
            e.hash    = succ ? K_HASH : 256'h0;
            e.ts      = ts + 32'(rolls);
            e.rolls   = 8'(rolls);
            sb.push_back(e);
        end
        tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin tick(); n++; end
        if (sb.size() != 0) begin
            chk("drain_timeout", 256'(sb.size()), 0);
            sb.delete();
        end
    endtask

    task automatic wait_start();
        int n = 0;
        while (!sup_start && n < 200) begin tick(); n++; end
        if (!sup_start) chk("start_timeout", sup_start, 1);
    endtask

    task automatic new_job_setup();
        run_base = run_idx;
        ts_log.delete();
        streak_log.delete();
    endtask

    logic [31:0] ts_exp [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    initial begin
        reset = 1'b1; job_valid = 1'b0; job_id = '0; job_version = '0; job_prev_hash = '0;
        job_merkle = '0; job_timestamp = '0; job_bits = '0; job_target = '0;
        abort = 1'b0; res_ready = 1'b1;

        // Reset state
        @(posedge clk); #1;
        chk("rst_job_ready", job_ready, 0);
        chk("rst_sup_reset", sup_reset, 1);
        chk("rst_sup_start", sup_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_sup_ts", sup_timestamp, 0);
        chk("rst_sup_merkle", sup_merkle, 0);
        chk("rst_res_nonce", res_nonce, 0);
        chk("rst_res_id", res_id, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_job_ready", job_ready, 1);

        // Single job, success at RUN cycle 10
        k_done = 10; k_fail = 0; new_job_setup(); lat_en = 1'b1;
        push_job(8'h11, 32'h5F00_0000, 1'b1, 1'b0, 0);
        wait_start();
        chk("hdr_version", sup_version, 32'h2000_0011);
        chk("hdr_prev_hash", sup_prev_hash, {32{8'h11}});
        chk("hdr_merkle", sup_merkle, ~{32{8'h11}});
        chk("hdr_bits", sup_bits, 32'h1703_0011);
        chk("hdr_target", sup_target, 32'd20);
        chk("hdr_ts", sup_timestamp, 32'h5F00_0000);
        wait_drain(200);
        lat_en = 1'b0;

        // Timestamp rollover across three failed runs
        k_done = 4; k_fail = 3; new_job_setup();
        push_job(8'h22, 32'hFFFF_FFFE, 1'b1, 1'b0, 3);
        wait_drain(400);
        chk("roll_launches", 256'(ts_log.size()), 4);
        for (int i = 0; i < 4; i++)
            if (i < ts_log.size()) chk($sformatf("roll_ts%0d", i), ts_log[i], ts_exp[i]);
        for (int i = 1; i < 4; i++)
            if (i < streak_log.size()) chk($sformatf("roll_rst_len%0d", i), 256'(streak_log[i]), RC);

        // Always failing: MAX_ROLLS+1 launches then a failure record
        k_done = 4; k_fail = 99; new_job_setup();
        push_job(8'h33, 32'h0000_1000, 1'b0, 1'b0, MAXR);
        wait_drain(400);
        chk("fail_launches", 256'(ts_log.size()), MAXR + 1);
        if (ts_log.size() == MAXR + 1) chk("fail_last_ts", ts_log[MAXR], 32'h0000_1004);

        // Back-pressure: three jobs queued while results are held
        k_done = 3; k_fail = 0; new_job_setup(); res_ready = 1'b0;
        push_job(8'h41, 32'h100, 1'b1, 1'b0, 0);
        push_job(8'h42, 32'h200, 1'b1, 1'b0, 0);
        push_job(8'h43, 32'h300, 1'b1, 1'b0, 0);
        tick(); tick(); tick();
        chk("bp_job_ready_full", job_ready, 0);
        for (int j = 0; j < 3; j++) begin
            int n = 0;
            while (!res_valid && n < 100) begin tick(); n++; end
            for (int k = 0; k < 5; k++) tick();
            chk($sformatf("bp_hold_valid%0d", j), res_valid, 1);
            chk($sformatf("bp_hold_id%0d", j), res_id, 8'(8'h41 + j));
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            if (j == 0) begin
                tick(); tick();
                chk("bp_job_ready_free", job_ready, 1);
            end
        end
        chk("bp_all_out", 256'(sb.size()), 0);
        res_ready = 1'b1;

        // Abort coinciding with post-guard complete+success
        k_done = 5; k_fail = 0; new_job_setup();
        push_job(8'h55, 32'h0000_5555, 1'b0, 1'b1, 0);
        wait_start();
        for (int k = 0; k < 5; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_drain(100);

        // Stale complete during RUN cycles 0-1 must be ignored
        k_done = 6; k_fail = 0; k_stale = 1'b1; new_job_setup();
        push_job(8'h66, 32'h0000_6666, 1'b1, 1'b0, 0);
        wait_drain(200);
        k_stale = 1'b0;
        chk("stale_launches", 256'(ts_log.size()), 1);

        // Reset mid-RUN with a second job queued
        k_done = 50; k_fail = 0; new_job_setup();
        push_job(8'h77, 32'h0000_7777, 1'b1, 1'b0, 0);
        push_job(8'h78, 32'h0000_7878, 1'b1, 1'b0, 0);
        wait_start();
        tick(); tick(); tick();
        reset = 1'b1;
        sb.delete();
        tick();
        chk("mid_rst_sup_reset", sup_reset, 1);
        chk("mid_rst_sup_start", sup_start, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        reset = 1'b0;
        ts_log.delete();
        for (int k = 0; k < 80; k++) tick();
        chk("mid_rst_no_launch", 256'(ts_log.size()), 0);
        chk("mid_rst_idle_reset", sup_reset, 1);
        chk("mid_rst_idle_start", sup_start, 0);
        chk("mid_rst_no_result", res_valid, 0);
        chk("mid_rst_job_ready", job_ready, 1);

        chk("sb_empty", 256'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
